// File: rtl/dht11_controller.sv
// Host-side DHT11 single-wire controller: issues the start pulse, times the sensor
// response, shifts in the 40-bit frame and validates it against the checksum byte.
module dht11_controller #(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int START_LOW_US  = 18_000,
  parameter int START_REL_US  = 30,
  parameter int TIMEOUT_US    = 200,
  parameter int BIT_THRESH_US = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  inout  wire        dht_io,
  output logic [7:0] humi_integral,
  output logic [7:0] humi_decimal,
  output logic [7:0] temp_integral,
  output logic [7:0] temp_decimal,
  output logic [7:0] parity,
  output logic       data_valid,
  output logic       checksum_err,
  output logic       timeout_err,
  output logic       busy
);

  localparam int          TICK_DIV     = (CLK_FREQ_HZ / 1_000_000 >= 1) ? CLK_FREQ_HZ / 1_000_000 : 1;
  localparam logic [31:0] TICK_LAST    = 32'(TICK_DIV - 1);
  localparam logic [15:0] START_LOW_T  = 16'(START_LOW_US);
  localparam logic [15:0] START_REL_T  = 16'(START_REL_US);
  localparam logic [15:0] TIMEOUT_T    = 16'(TIMEOUT_US);
  localparam logic [15:0] THRESH_T     = 16'(BIT_THRESH_US);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_START_LOW = 4'd1;
  localparam logic [3:0] S_START_REL = 4'd2;
  localparam logic [3:0] S_WAIT_RESP = 4'd3;
  localparam logic [3:0] S_RESP_LOW  = 4'd4;
  localparam logic [3:0] S_RESP_HIGH = 4'd5;
  localparam logic [3:0] S_BIT_LOW   = 4'd6;
  localparam logic [3:0] S_BIT_HIGH  = 4'd7;
  localparam logic [3:0] S_CHECK     = 4'd8;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic checksum_ok(input logic [39:0] f);
    logic [7:0] s;
    s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return s == f[7:0];
  endfunction

  logic [3:0]  state, state_nx;
  logic [31:0] tick_cnt;
  logic        tick;
  logic [15:0] us_cnt;
  logic [5:0]  bit_cnt;
  logic [39:0] shift_reg;
  logic        line_p0, line_p1, line_p2;
  logic        rise, fall, timed;
  logic        shift_en, set_valid, set_cksum, set_tout;

  // Open-drain: the host only ever pulls low, the external pull-up supplies the high.
  assign dht_io = (state == S_START_LOW) ? 1'b0 : 1'bz;
  assign busy   = (state != S_IDLE);
  assign tick   = (tick_cnt == TICK_LAST);
  assign rise   = line_p1 & ~line_p2;
  assign fall   = ~line_p1 & line_p2;
  assign timed  = (us_cnt > TIMEOUT_T);

  always_comb begin
    state_nx  = state;
    shift_en  = 1'b0;
    set_valid = 1'b0;
    set_cksum = 1'b0;
    set_tout  = 1'b0;
    case (state)
      S_IDLE:      if (start) state_nx = S_START_LOW;
      S_START_LOW: if (us_cnt == START_LOW_T) state_nx = S_START_REL;
      S_START_REL: if (us_cnt == START_REL_T) state_nx = S_WAIT_RESP;
      S_WAIT_RESP, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH: begin
        if (timed) begin
          state_nx = S_IDLE;
          set_tout = 1'b1;
        end else begin
          case (state)
            S_WAIT_RESP: if (!line_p1) state_nx = S_RESP_LOW;
            S_RESP_LOW:  if (rise) state_nx = S_RESP_HIGH;
            S_RESP_HIGH: if (fall) state_nx = S_BIT_LOW;
            S_BIT_LOW:   if (rise) state_nx = S_BIT_HIGH;
            default: begin
              if (fall) begin
                shift_en = 1'b1;
                state_nx = (bit_cnt == 6'd39) ? S_CHECK : S_BIT_LOW;
              end
            end
          endcase
        end
      end
      S_CHECK: begin
        state_nx = S_IDLE;
        if (checksum_ok(shift_reg)) set_valid = 1'b1;
        else                        set_cksum = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Stage p0/p1: two-flop synchronizer; p2 holds the previous sample for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      line_p0 <= 1'b1;
      line_p1 <= 1'b1;
      line_p2 <= 1'b1;
    end else begin
      line_p0 <= dht_io;
      line_p1 <= line_p0;
      line_p2 <= line_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      tick_cnt      <= '0;
      us_cnt        <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      humi_integral <= '0;
      humi_decimal  <= '0;
      temp_integral <= '0;
      temp_decimal  <= '0;
      parity        <= '0;
      data_valid    <= 1'b0;
      checksum_err  <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state        <= state_nx;
      tick_cnt     <= tick ? '0 : tick_cnt + 32'd1;
      data_valid   <= set_valid;
      checksum_err <= set_cksum;
      timeout_err  <= set_tout;
      if (state_nx != state) us_cnt <= '0;
      else if (tick)         us_cnt <= sat_inc(us_cnt);
      if (state == S_RESP_HIGH && state_nx == S_BIT_LOW) bit_cnt <= '0;
      // Bit value is decided by how long the line stayed high, MSB first.
      if (shift_en) begin
        shift_reg <= {shift_reg[38:0], (us_cnt >= THRESH_T)};
        bit_cnt   <= bit_cnt + 6'd1;
      end
      if (set_valid) begin
        humi_integral <= shift_reg[39:32];
        humi_decimal  <= shift_reg[31:24];
        temp_integral <= shift_reg[23:16];
        temp_decimal  <= shift_reg[15:8];
        parity        <= shift_reg[7:0];
      end
    end
  end

endmodule

// File: tb/tb_dht11_controller.sv
// Bench for dht11_controller: pull-up bus plus a DHT11 sensor model with randomized
// frame contents and phase timings, checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_dht11_controller;
  localparam int START_LOW = 100;
  localparam int START_REL = 30;
  localparam int TIMEOUT   = 200;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic sensor_low = 1'b0;
  wire  dht_io;
  logic [7:0] humi_integral, humi_decimal, temp_integral, temp_decimal, parity;
  logic data_valid, checksum_err, timeout_err, busy;

  int checks = 0;
  int failures = 0;
  int n_dv = 0, n_ck = 0, n_to = 0, n_multi = 0;
  logic [39:0] exp_out = '0;

  always #500 clk = ~clk;

  pullup (dht_io);
  assign dht_io = sensor_low ? 1'b0 : 1'bz;

  dht11_controller #(
    .CLK_FREQ_HZ(1_000_000), .START_LOW_US(START_LOW), .START_REL_US(START_REL),
    .TIMEOUT_US(TIMEOUT), .BIT_THRESH_US(50)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .dht_io(dht_io),
    .humi_integral(humi_integral), .humi_decimal(humi_decimal),
    .temp_integral(temp_integral), .temp_decimal(temp_decimal), .parity(parity),
    .data_valid(data_valid), .checksum_err(checksum_err), .timeout_err(timeout_err),
    .busy(busy)
  );

  // Pulse-cycle counters; a flag held two cycles shows up as a count of two.
  always @(negedge clk) begin
    if (data_valid === 1'b1) n_dv++;
    if (checksum_err === 1'b1) n_ck++;
    if (timeout_err === 1'b1) n_to++;
    if (int'(data_valid) + int'(checksum_err) + int'(timeout_err) > 1) n_multi++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [39:0] outs();
    return {humi_integral, humi_decimal, temp_integral, temp_decimal, parity};
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sensor: answer the host start, then send nbits of f MSB-first with jittered timings.
  task automatic sensor_frame(input logic [39:0] f, input int nbits, input int start_bit,
                              output int low_len);
    int t;
    t = 0;
    while (dht_io !== 1'b0 && t < 500) begin @(negedge clk); t++; end
    t = 0;
    while (dht_io !== 1'b1 && t < START_LOW + 50) begin @(negedge clk); t++; end
    low_len = t;
    hold($urandom_range(40, 20));
    sensor_low = 1'b1; hold(80);
    sensor_low = 1'b0; hold(80);
    for (int i = 0; i < nbits; i++) begin
      sensor_low = 1'b1;
      if (i == start_bit) begin
        hold(5);
        start = 1'b1; hold(1); start = 1'b0;
        hold(45);
      end else begin
        hold($urandom_range(55, 45));
      end
      sensor_low = 1'b0;
      hold(f[39-i] ? $urandom_range(75, 65) : $urandom_range(30, 22));
    end
    if (nbits == 40) begin
      sensor_low = 1'b1; hold(50); sensor_low = 1'b0;
    end
  endtask

  task automatic do_frame(input string tag, input logic [39:0] f, input int nbits,
                          input int start_bit);
    int dv0, ck0, to0, mu0, low_len, t, sum;
    bit exp_dv, exp_ck, exp_to;
    dv0 = n_dv; ck0 = n_ck; to0 = n_to; mu0 = n_multi;
    pulse_start();
    sensor_frame(f, nbits, start_bit, low_len);
    t = 0;
    while (busy !== 1'b0 && t < 600) begin @(negedge clk); t++; end
    hold(3);
    sum = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
    exp_to = (nbits < 40);
    exp_dv = !exp_to && (sum == int'(f[7:0]));
    exp_ck = !exp_to && !exp_dv;
    if (exp_dv) exp_out = f;
    check({tag, "/start_low_len"}, 64'(low_len >= START_LOW && low_len <= START_LOW + 3), 64'd1);
    check({tag, "/busy"}, 64'(busy), 64'd0);
    check({tag, "/data_valid_cnt"}, 64'(n_dv - dv0), 64'(exp_dv));
    check({tag, "/checksum_err_cnt"}, 64'(n_ck - ck0), 64'(exp_ck));
    check({tag, "/timeout_err_cnt"}, 64'(n_to - to0), 64'(exp_to));
    check({tag, "/flag_overlap"}, 64'(n_multi - mu0), 64'd0);
    check({tag, "/out_bytes"}, 64'(outs()), 64'(exp_out));
  endtask

  initial begin
    int t, base;
    logic [7:0] b0, b1, b2, b3, s;
    // Reset state
    rst = 1'b0;
    hold(3);
    check("reset/out_bytes", 64'(outs()), 64'd0);
    check("reset/busy", 64'(busy), 64'd0);
    check("reset/line_released", 64'(dht_io), 64'd1);
    check("reset/flags", 64'({data_valid, checksum_err, timeout_err}), 64'd0);
    rst = 1'b1;
    hold(3);

    do_frame("t1_good", 40'h37_00_18_00_4F, 40, -1);
    check("t1/humi_int", 64'(humi_integral), 64'd55);
    check("t1/temp_int", 64'(temp_integral), 64'd24);
    check("t1/parity", 64'(parity), 64'h4F);

    do_frame("t2_badsum", 40'h37_00_18_00_50, 40, -1);

    // No sensor: measure release-to-timeout distance.
    base = n_to;
    pulse_start();
    t = 0;
    while (dht_io !== 1'b1 && t < START_LOW + 50) begin @(negedge clk); t++; end
    t = 0;
    while (timeout_err !== 1'b1 && t < 400) begin @(negedge clk); t++; end
    check("t3/timeout_latency",
          64'(t >= START_REL + TIMEOUT && t <= START_REL + TIMEOUT + 5), 64'd1);
    hold(3);
    check("t3/timeout_cnt", 64'(n_to - base), 64'd1);
    check("t3/busy", 64'(busy), 64'd0);
    check("t3/out_hold", 64'(outs()), 64'(exp_out));

    do_frame("t4_stall", 40'h12_34_56_78_14, 12, -1);
    do_frame("t4_recover", 40'h41_02_19_03_5F, 40, -1);

    do_frame("t5_start_in_bit", 40'hFF_FF_01_00_FF, 40, 5);

    for (int k = 0; k < 5; k++) begin
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
      s = 8'((int'(b0) + int'(b1) + int'(b2) + int'(b3)) % 256);
      if (k >= 3) s = s ^ 8'($urandom_range(255, 1));
      do_frame($sformatf("rand%0d", k), {b0, b1, b2, b3, s}, 40, -1);
    end

    // Reset in START_LOW; start asserted on the same edges as reset.
    base = n_dv + n_ck + n_to;
    pulse_start();
    hold(10);
    check("t6/host_driving", 64'(dht_io), 64'd0);
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6/line_released", 64'(dht_io), 64'd1);
    check("t6/busy", 64'(busy), 64'd0);
    check("t6/out_cleared", 64'(outs()), 64'd0);
    hold(2);
    rst = 1'b1;
    hold(2);
    check("t6/busy_after", 64'(busy), 64'd0);
    check("t6/no_pulses", 64'(n_dv + n_ck + n_to - base), 64'd0);
    exp_out = '0;

    do_frame("t6_recover", 40'h2D_05_16_07_4F, 40, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
